mult_rr_arbiter: RTL and testbench

- Shares one sequential shift-add multiplier between NUM_REQ requesters.
- Round-robin arbitration among pending requests; the winner's operands are latched and a one-cycle start pulse is issued to the multiplier.
- Waits for the multiplier's done indication, or a timeout, then returns the product with an ack to the winner.
- Sits between client blocks and the multiplier's DP_B/DP_Q/Producto interface.

---
 rtl/mult_rr_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mult_rr_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin front end that shares one sequential shift-add
// multiplier between NUM_REQ clients. A winner's operands are latched at grant,
// the multiplier is started with a one-cycle pulse, and the product (or a
// timeout error) is returned to the winner with a one-cycle ack.
//
// Timeout counting: the counter is 0 during LAUNCH and advances once per cycle
// afterwards, so an unanswered transaction acks exactly TIMEOUT cycles after
// the LAUNCH cycle. TIMEOUT must be at least 2.
module mult_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DW      = 8,
   parameter int unsigned PW      = 17,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*DW-1:0] req_a,
   input  logic [NUM_REQ*DW-1:0] req_b,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    ack,
   output logic [PW-1:0]         res_product,
   output logic                  res_err,
   output logic                  busy,
   output logic                  mul_start,
   output logic [DW-1:0]         mul_a,
   output logic [DW-1:0]         mul_b,
   input  logic                  mul_done,
   input  logic [PW-1:0]         mul_product
);

   localparam int unsigned PtrW = $clog2(NUM_REQ);
   localparam int unsigned SumW = PtrW + 1;
   localparam int unsigned CntW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StWait,
      StResp
   } state_e;

   state_e               state_q, state_d;
   logic [PtrW-1:0]      ptr_q, ptr_d;
   logic [PtrW-1:0]      win_q, win_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [PW-1:0]        res_product_q, res_product_d;
   logic                 res_err_q, res_err_d;
   logic                 busy_q, busy_d;
   logic                 mul_start_q, mul_start_d;
   logic [DW-1:0]        mul_a_q, mul_a_d;
   logic [DW-1:0]        mul_b_q, mul_b_d;

   // Arbitration results
   logic                 win_found;
   logic [PtrW-1:0]      win_idx;
   logic [SumW-1:0]      cand_sum;
   logic [PtrW-1:0]      cand;
   logic [DW-1:0]        a_sel;
   logic [DW-1:0]        b_sel;
   logic [PtrW-1:0]      ptr_next;

   // Round-robin search: first pending request at ptr, ptr+1, ... modulo NUM_REQ
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand_sum  = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand_sum = {1'b0, ptr_q} + SumW'(i);
         if (cand_sum >= SumW'(NUM_REQ)) begin
            cand_sum = cand_sum - SumW'(NUM_REQ);
         end
         cand = cand_sum[PtrW-1:0];
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Operand mux for the current arbitration winner
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_idx == PtrW'(i)) begin
            a_sel = req_a[i*DW +: DW];
            b_sel = req_b[i*DW +: DW];
         end
      end
   end

   // Pointer moves to the requester after the one being served
   always_comb begin
      if (win_q == PtrW'(NUM_REQ - 1)) begin
         ptr_next = '0;
      end else begin
         ptr_next = win_q + PtrW'(1);
      end
   end

   // Next-state and registered-output logic of the transaction FSM
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      win_d         = win_q;
      cnt_d         = cnt_q;
      gnt_d         = gnt_q;
      ack_d         = '0;
      res_product_d = res_product_q;
      res_err_d     = 1'b0;
      mul_start_d   = 1'b0;
      mul_a_d       = mul_a_q;
      mul_b_d       = mul_b_q;

      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               win_d          = win_idx;
               mul_a_d        = a_sel;
               mul_b_d        = b_sel;
               gnt_d          = '0;
               gnt_d[win_idx] = 1'b1;
               mul_start_d    = 1'b1;
               cnt_d          = '0;
               state_d        = StLaunch;
            end
         end
         StLaunch: begin
            // mul_done is deliberately not looked at here
            cnt_d   = CntW'(1);
            state_d = StWait;
         end
         StWait: begin
            if (mul_done) begin
               res_product_d = mul_product;
               res_err_d     = 1'b0;
               ack_d         = gnt_q;
               ptr_d         = ptr_next;
               state_d       = StResp;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               res_product_d = '0;
               res_err_d     = 1'b1;
               ack_d         = gnt_q;
               ptr_d         = ptr_next;
               state_d       = StResp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StResp: begin
            gnt_d   = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   // State and output registers, cleared asynchronously by rst
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         ptr_q         <= '0;
         win_q         <= '0;
         cnt_q         <= '0;
         gnt_q         <= '0;
         ack_q         <= '0;
         res_product_q <= '0;
         res_err_q     <= 1'b0;
         busy_q        <= 1'b0;
         mul_start_q   <= 1'b0;
         mul_a_q       <= '0;
         mul_b_q       <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         win_q         <= win_d;
         cnt_q         <= cnt_d;
         gnt_q         <= gnt_d;
         ack_q         <= ack_d;
         res_product_q <= res_product_d;
         res_err_q     <= res_err_d;
         busy_q        <= busy_d;
         mul_start_q   <= mul_start_d;
         mul_a_q       <= mul_a_d;
         mul_b_q       <= mul_b_d;
      end
   end

   assign gnt         = gnt_q;
   assign ack         = ack_q;
   assign res_product = res_product_q;
   assign res_err     = res_err_q;
   assign busy        = busy_q;
   assign mul_start   = mul_start_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Testbench for mult_rr_arbiter: behavioural multiplier with programmable
// latency plus a transaction-level model of arbitration, latency and results.
module tb_mult_rr_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned PW = 17;
   localparam int unsigned TO = 64;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req;
   logic [N*DW-1:0]   req_a;
   logic [N*DW-1:0]   req_b;
   logic [N-1:0]      gnt;
   logic [N-1:0]      ack;
   logic [PW-1:0]     res_product;
   logic              res_err;
   logic              busy;
   logic              mul_start;
   logic [DW-1:0]     mul_a;
   logic [DW-1:0]     mul_b;
   logic              mul_done;
   logic [PW-1:0]     mul_product;

   logic [DW-1:0]     op_a [N];
   logic [DW-1:0]     op_b [N];

   int mul_lat;     // -1: never answers, 0: pulse only in the start cycle
   int n_checks;
   int n_fail;
   int model_ptr;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_a[i*DW +: DW] = op_a[i];
         req_b[i*DW +: DW] = op_b[i];
      end
   end

   mult_rr_arbiter #(
      .NUM_REQ (N),
      .DW      (DW),
      .PW      (PW),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_a       (req_a),
      .req_b       (req_b),
      .gnt         (gnt),
      .ack         (ack),
      .res_product (res_product),
      .res_err     (res_err),
      .busy        (busy),
      .mul_start   (mul_start),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_done    (mul_done),
      .mul_product (mul_product)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration: first set bit from p upwards, wrapping
   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (p + k) % N;
         if (r[idx]) return idx;
      end
      return -1;
   endfunction

   // Multiplier answers in time only if done lands strictly inside WAIT
   function automatic bit lat_ok(input int lat);
      return (lat >= 1) && (lat <= TO - 1);
   endfunction

   // Behavioural multiplier: done pulse mul_lat cycles after the start cycle
   initial begin
      int   since;
      bit   pend;
      logic [PW-1:0] prod;
      mul_done    = 1'b0;
      mul_product = '0;
      pend        = 1'b0;
      since       = 0;
      prod        = '0;
      forever begin
         @(negedge clk);
         mul_done    = 1'b0;
         mul_product = PW'($urandom);
         if (!rst) begin
            pend = 1'b0;
         end else if (mul_start) begin
            prod  = mul_a * mul_b;
            since = 0;
            pend  = 1'b1;
            if (mul_lat == 0) begin
               mul_done    = 1'b1;
               mul_product = prod;
               pend        = 1'b0;
            end
         end else if (pend) begin
            since++;
            if (mul_lat > 0 && since == mul_lat) begin
               mul_done    = 1'b1;
               mul_product = prod;
               pend        = 1'b0;
            end
         end
      end
   end

   // One transaction, entered at a negedge in IDLE with req already driven
   task automatic run_txn(input int lat, input bit reassert, output logic [N-1:0] g_obs);
      int            w;
      int            cyc;
      int            starts;
      bit            got;
      bit            gnt_bad;
      logic [N-1:0]  oh;
      logic [DW-1:0] ea;
      logic [DW-1:0] eb;
      logic [PW-1:0] eprod;
      g_obs = '0;
      w = rr_pick(req, model_ptr);
      if (w < 0) begin
         check_eq("req_nonzero", 0, 1);
         return;
      end
      oh      = '0;
      oh[w]   = 1'b1;
      ea      = op_a[w];
      eb      = op_b[w];
      eprod   = ea * eb;
      mul_lat = lat;

      @(negedge clk);
      g_obs = gnt;
      check_eq("launch_gnt", gnt, oh);
      check_eq("launch_start", mul_start, 1);
      check_eq("launch_ops", {mul_a, mul_b}, {ea, eb});
      check_eq("launch_busy", busy, 1);
      // Operand changes after grant must not reach the multiplier
      op_a[w] = ~ea;
      op_b[w] = ~eb;

      starts  = 1;
      cyc     = 0;
      got     = 1'b0;
      gnt_bad = 1'b0;
      while (!got && cyc < int'(TO) + 4) begin
         @(negedge clk);
         cyc++;
         if (mul_start) starts++;
         if (gnt !== oh) gnt_bad = 1'b1;
         if (ack != '0) got = 1'b1;
      end
      check_eq("ack_seen", got, 1);
      check_eq("ack_latency", cyc, lat_ok(lat) ? lat + 1 : int'(TO));
      check_eq("ack_onehot", ack, oh);
      check_eq("res_err", res_err, lat_ok(lat) ? 1'b0 : 1'b1);
      check_eq("res_product", res_product, lat_ok(lat) ? eprod : '0);
      check_eq("start_count", starts, 1);
      check_eq("gnt_hold", gnt_bad, 0);
      check_eq("resp_busy", busy, 1);

      if (!reassert) req[w] = 1'b0;
      model_ptr = (w + 1) % N;

      @(negedge clk);
      check_eq("idle_clear", {gnt, ack, res_err, busy, mul_start}, 0);
      check_eq("ops_hold", {mul_a, mul_b}, {ea, eb});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = '0;
      #1;
      check_eq("rst_out", {gnt, ack, res_product, res_err, busy, mul_start, mul_a, mul_b}, 0);
      repeat (2) @(negedge clk);
      rst       = 1'b1;
      model_ptr = 0;
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] g;
      logic [N-1:0] new_mask;
      bit           noack;
      int           rr_exp [5];
      int           lat;
      int           sel;
      n_checks  = 0;
      n_fail    = 0;
      model_ptr = 0;
      mul_lat   = -1;
      rst       = 1'b0;
      req       = '0;
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      rr_exp = '{0, 1, 2, 3, 0};

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("reset_state", {gnt, ack, res_product, res_err, busy, mul_start, mul_a, mul_b}, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single request: 23 * 17 = 391
      op_a[0] = 8'd23;
      op_b[0] = 8'd17;
      req     = 4'b0001;
      run_txn(9, 1'b0, g);
      check_eq("single_gnt", g, 4'b0001);

      // Round robin with all requesters re-asserting
      do_reset();
      for (int i = 0; i < N; i++) begin
         op_a[i] = DW'($urandom);
         op_b[i] = DW'($urandom);
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         run_txn(int'($urandom_range(1, 12)), 1'b1, g);
         check_eq("rr_order", g, 4'b0001 << rr_exp[k]);
      end

      // Pointer wrap: serve 3, then 1001 must go to 0
      req = 4'b1000;
      run_txn(4, 1'b0, g);
      check_eq("serve3_gnt", g, 4'b1000);
      req = 4'b1001;
      run_txn(2, 1'b0, g);
      check_eq("wrap_gnt", g, 4'b0001);

      // Timeout, then a normal request
      req = 4'b0001;
      run_txn(-1, 1'b0, g);
      req = 4'b0010;
      run_txn(3, 1'b0, g);
      check_eq("after_to_gnt", g, 4'b0010);

      // Boundary latencies: coincidence, one too late, done in LAUNCH, fastest
      req = 4'b0100;
      run_txn(int'(TO) - 1, 1'b0, g);
      req = 4'b0100;
      run_txn(int'(TO), 1'b0, g);
      req = 4'b0100;
      run_txn(0, 1'b0, g);
      req = 4'b0100;
      run_txn(1, 1'b0, g);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         new_mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            if (!req[i]) begin
               op_a[i] = DW'($urandom);
               op_b[i] = DW'($urandom);
            end
         end
         req = new_mask;
         sel = int'($urandom_range(0, 9));
         if (sel <= 5)      lat = int'($urandom_range(1, 12));
         else if (sel == 6) lat = int'(TO) - 1;
         else if (sel == 7) lat = -1;
         else if (sel == 8) lat = 0;
         else               lat = int'($urandom_range(TO - 3, TO + 1));
         run_txn(lat, 1'($urandom_range(0, 1)), g);
      end

      // Asynchronous reset in the middle of WAIT
      req     = 4'b0001;
      op_a[0] = 8'h5a;
      op_b[0] = 8'h3c;
      mul_lat = -1;
      @(negedge clk);
      check_eq("prerst_gnt", gnt, 4'b0001);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      req = '0;
      #1;
      check_eq("midrst_out", {gnt, ack, res_product, res_err, busy, mul_start, mul_a, mul_b}, 0);
      noack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (ack != '0 || busy) noack = 1'b0;
      end
      check_eq("midrst_noack", noack, 1);
      rst       = 1'b1;
      model_ptr = 0;
      @(negedge clk);
      op_a[2] = 8'd255;
      op_b[2] = 8'd255;
      req     = 4'b0100;
      run_txn(9, 1'b0, g);
      check_eq("postrst_gnt", g, 4'b0100);

      // Pointer back at 0 after reset: 1100 goes to 2, not 3
      do_reset();
      req = 4'b1100;
      run_txn(5, 1'b0, g);
      check_eq("rst_ptr_gnt", g, 4'b0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
